// File: rtl/periph_stream_mux_pkg.sv
// Shared types and constants for periph_stream_mux.
// FSM encoding: RUN (forwarding on cur_sel), SWITCH (draining before committing a new channel).
package periph_stream_mux_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SWITCH = 1'b1
  } mux_state_e;

  localparam logic [0:0] ST_RUN    = RUN;
  localparam logic [0:0] ST_SWITCH = SWITCH;

endpackage

// File: rtl/periph_stream_mux_if.sv
// Stream bundle for periph_stream_mux: NCH valid/ready inputs and one registered output.
//   in_data   : NCH*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid      in_ready  : per-channel ready
//   out_data  : output data            out_valid : output valid   out_ready : downstream ready
// slave = mux side, master = producer/consumer side.
interface periph_stream_mux_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8
);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/periph_stream_mux_rr_next.sv
// periph_rr_next: combinational search for the next valid channel after cur,
// scanning cur+1 upward and wrapping at NCH-1 -> 0; cur itself is not a candidate.
//   cur   : current channel index
//   valid : per-channel valid vector
//   nxt   : next valid channel (cur when none found)
//   found : another valid channel exists
module periph_rr_next #(
  parameter  int unsigned NCH   = 4,
  localparam int unsigned SEL_W = $clog2(NCH)
) (
  input  logic [SEL_W-1:0] cur,
  input  logic [NCH-1:0]   valid,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  int unsigned idx;

  // First hit in the rotated scan wins.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k < NCH; k++) begin
      idx = (32'(cur) + k) % NCH;
      if (!found && valid[idx]) begin
        found = 1'b1;
        nxt   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/periph_stream_mux.sv
// periph_stream_mux: NCH-channel registered stream mux; channel switches commit only at
// beat boundaries. Optional round-robin mode under macro PERIPH_STREAM_MUX_RR_EN.
//   clk, rst_n : clock, async active-low reset
//   bus        : stream bundle (slave modport)
//   sel        : requested channel       sel_load : one-cycle switch request
//   rr_mode    : round-robin enable (PERIPH_STREAM_MUX_RR_EN builds only)
//   cur_sel    : committed channel       switching: switch pending
//   sel_err    : one-cycle pulse after a sel_load with sel >= NCH
module periph_stream_mux
  import periph_stream_mux_pkg::*;
#(
  parameter  int unsigned NCH   = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  periph_stream_mux_if.slave bus,
`ifdef PERIPH_STREAM_MUX_RR_EN
  input  logic             rr_mode,
`endif
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_load,
  output logic [SEL_W-1:0] cur_sel,
  output logic             switching,
  output logic             sel_err
);

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic [SEL_W-1:0] eff_pend;
  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] chan_data;
  logic             accept, drain, sel_ok, rr_active;
  logic [NCH-1:0]   in_ready_c;

`ifdef PERIPH_STREAM_MUX_RR_EN
  logic [SEL_W-1:0] rr_nxt;
  logic             rr_found;

  periph_rr_next #(.NCH(NCH)) u_rr_next (
    .cur   (cur_q),
    .valid (bus.in_valid),
    .nxt   (rr_nxt),
    .found (rr_found)
  );

  assign rr_active = rr_mode;
`else
  assign rr_active = 1'b0;
`endif

  assign sel_ok = (32'(sel) < NCH);

  // Handshake qualifiers; ready depends only on state and out_ready.
  always_comb begin
    chan_data = bus.in_data[32'(cur_q)*WIDTH +: WIDTH];
    accept    = (state_q == ST_RUN) && bus.in_valid[cur_q] && (!full_q || bus.out_ready);
    drain     = full_q && bus.out_ready;
  end

  // Per-channel ready, forced low while reset is asserted.
  always_comb begin
    in_ready_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      in_ready_c[i] = rst_n && (state_q == ST_RUN) && (32'(cur_q) == i)
                      && (!full_q || bus.out_ready);
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    data_d   = data_q;
    full_d   = full_q;
    err_d    = 1'b0;
    eff_pend = pend_q;

    if (accept) begin
      data_d = chan_data;
      full_d = 1'b1;
    end else if (drain) begin
      full_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (sel_load && !rr_active) begin
          if (!sel_ok) begin
            err_d = 1'b1;
          end else if (sel != cur_q) begin
            pend_d  = sel;
            state_d = ST_SWITCH;
          end
        end
`ifdef PERIPH_STREAM_MUX_RR_EN
        // Accepted beat already sits in the register, so advance without SWITCH.
        if (rr_active && accept && rr_found) begin
          cur_d = rr_nxt;
        end
`endif
      end
      ST_SWITCH: begin
        // Last valid request wins, even in the commit cycle.
        if (sel_load && !rr_active) begin
          if (!sel_ok) begin
            err_d = 1'b1;
          end else begin
            pend_d   = sel;
            eff_pend = sel;
          end
        end
        if (!full_q || drain) begin
          cur_d   = eff_pend;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cur_q   <= '0;
      pend_q  <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = data_q;
  assign bus.out_valid = full_q;
  assign cur_sel       = cur_q;
  assign switching     = (state_q == ST_SWITCH);
  assign sel_err       = err_q;

endmodule

// File: doc/periph_stream_mux.md
Name: periph_stream_mux

Overview:
- Parametrised N-channel registered stream multiplexer for the Peripheral Unit.
- Successor to the fixed 4:1 combinational select mux.
- Routes one of NCH valid/ready input streams to a single registered output stream.
- Channel switches are committed only at beat boundaries, so no beat is dropped, duplicated or mixed across channels.

Parameters:
- NCH, 4, number of input channels (>=2).
- WIDTH, 8, data width per channel.
- SEL_W, $clog2(NCH), select width (derived; not overridden).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- SEL  in  SEL_W  requested channel.
- SEL_LOAD  in  1  one-cycle pulse: request switch to SEL.
- IN_DATA  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- IN_VALID  in  NCH  per-channel valid.
- IN_READY  out  NCH  per-channel ready.
- OUT_DATA  out  WIDTH  registered output data.
- OUT_VALID  out  1  output valid.
- OUT_READY  in  1  downstream ready.
- CUR_SEL  out  SEL_W  currently committed channel.
- SWITCHING  out  1  switch pending (FSM in SWITCH).
- SEL_ERR  out  1  one-cycle pulse: SEL_LOAD with SEL >= NCH.

Behaviour:
- Reset (async, RST_N=0):
  - CUR_SEL=0, OUT_VALID=0, OUT_DATA=0, SWITCHING=0, SEL_ERR=0, FSM=RUN, pending select cleared.
  - IN_READY=0 while RST_N=0.
- Output stage: one register with a full flag. OUT_VALID = full.
  - OUT_DATA holds stable while OUT_VALID=1 and OUT_READY=0.
- IN_READY[i] = (FSM==RUN) && (i==CUR_SEL) && (!full || OUT_READY). Combinational from state and OUT_READY only.
  - No combinational path from IN_VALID to IN_READY.
- Accept: IN_VALID[CUR_SEL] && IN_READY[CUR_SEL] loads the output register. OUT_VALID=1 next cycle (latency 1).
  - Accept plus simultaneous output handshake: register reloads, full stays 1. Full throughput of 1 beat/cycle.
- Output handshake without accept: full clears next cycle.
- FSM RUN:
  - SEL_LOAD with SEL<NCH and SEL!=CUR_SEL: latch pend=SEL, go to SWITCH. Any accept in that same cycle completes on the old channel.
  - SEL_LOAD with SEL==CUR_SEL: no-op.
  - SEL_LOAD with SEL>=NCH: ignored; SEL_ERR pulses 1 cycle; state unchanged.
- FSM SWITCH:
  - All IN_READY=0.
  - When output is empty, or is emptying this cycle (OUT_VALID && OUT_READY): CUR_SEL<=pend, go to RUN. The new channel can be accepted the cycle after.
  - SEL_LOAD while in SWITCH: pend overwritten if SEL valid (last request wins); SEL_ERR if invalid.
- Reset mid-operation: pending switch and buffered beat are discarded.
- Downstream must tolerate the loss of a beat that was in flight at reset.

Optional Feature:
- Macro PERIPH_STREAM_MUX_RR_EN.
- Defined: adds input RR_MODE (1 bit).
  - While RR_MODE=1, SEL_LOAD is ignored (no SEL_ERR).
  - After every accepted beat, CUR_SEL advances to the next channel with IN_VALID high, searching CUR_SEL+1 upward and wrapping at NCH-1 -> 0.
  - If no other channel is valid, CUR_SEL holds.
  - This advance is immediate and does not pass through SWITCH, since the accepted beat already occupies the register.
  - RR_MODE 1->0 transition: CUR_SEL is kept.
- Undefined: no RR_MODE port; selection is by SEL_LOAD only.

Decomposition:
- Package periph_stream_mux_pkg: FSM state enum mux_state_e {RUN, SWITCH}.
- One sub-module: periph_rr_next (combinational next-valid-channel finder: inputs current index and valid vector; outputs next index and found flag). Instantiated only under PERIPH_STREAM_MUX_RR_EN.

Test Plan (NCH=4, WIDTH=8):
- Reset, then IN_VALID=4'b0001, IN_DATA ch0=8'hA5, OUT_READY=1 -> OUT_VALID=1 with OUT_DATA=8'hA5 one cycle after accept; sustained valid gives 1 beat/cycle.
- OUT_READY=0 for 3 cycles with ch0 streaming -> OUT_DATA holds its first value, IN_READY[0]=0 while full, no beat lost when OUT_READY returns to 1.
- Full output, OUT_READY=0, SEL_LOAD with SEL=2 -> SWITCHING=1, all IN_READY=0. OUT_READY=1 -> CUR_SEL=2 that cycle edge; ch2 beat 8'h3C appears 2 cycles later.
- SEL_LOAD with SEL=3 while in SWITCH with pend=1 -> commits CUR_SEL=3. SEL=3'b… out of range (NCH=3 build, SEL=3) -> SEL_ERR pulse, CUR_SEL unchanged.
- RST_N pulled low mid-stream while full -> OUT_VALID=0 and CUR_SEL=0 immediately, without waiting for a clock edge.
- RR build, RR_MODE=1, IN_VALID=4'b1011, OUT_READY=1 -> accepted order ch0, ch1, ch3, ch0 …
